// File: rtl/muldiv_sched_if.sv
// Pipeline-side handshake bundle for the multiply/divide sequencer.
// The pipeline drives through the master modport; the sequencer sits on the slave.
interface muldiv_sched_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             rd_hilo;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, a, b, flush, rd_hilo, wr_hi, wr_lo, wdata,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b, flush, rd_hilo, wr_hi, wr_lo, wdata,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_sched.sv
// Iterative MIPS mult/multu/div/divu sequencer owning HI/LO, with stall request.
// Define MULDIV_FAST_MUL_EN to run mult/multu through a single-cycle multiplier.
module muldiv_sched #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  muldiv_sched_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, RUN, FAST, FIN, DONE} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] work_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               is_div_reg;
  logic               neg_res_reg;
  logic               neg_rem_reg;
  logic               div_zero_reg;
  logic               done_reg;

  logic               signed_op;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               accept;

  assign signed_op = ~bus.op[0];
  assign sign_a    = signed_op & bus.a[WIDTH-1];
  assign sign_b    = signed_op & bus.b[WIDTH-1];
  assign abs_a     = sign_a ? -bus.a : bus.a;
  assign abs_b     = sign_b ? -bus.b : bus.b;
  assign accept    = (state_reg == IDLE) && bus.start && !bus.flush;

  // Shift-add step: work_reg = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]}
                  + {1'b0, (work_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, work_reg[WIDTH-1:1]};

  // Restoring step: work_reg = {remainder, dividend bits shifting into quotient}.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_reg};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  work_reg[WIDTH-2:0], 1'b1};

  // Sign fix-up applied on the way into HI/LO.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  assign prod_fix = neg_res_reg ? -work_reg : work_reg;
  assign quo_fix  = div_zero_reg ? {WIDTH{1'b1}}
                  : (neg_res_reg ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0]);
  assign rem_fix  = neg_rem_reg ? -work_reg[2*WIDTH-1:WIDTH] : work_reg[2*WIDTH-1:WIDTH];
  assign res_hi   = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      work_reg     <= '0;
      mcand_reg    <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      is_div_reg   <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            is_div_reg   <= bus.op[1];
            neg_res_reg  <= sign_a ^ sign_b;
            neg_rem_reg  <= sign_a;
            div_zero_reg <= bus.op[1] && (bus.b == '0);
            mcand_reg    <= abs_b;
            work_reg     <= {{WIDTH{1'b0}}, abs_a};
            cnt_reg      <= '0;
`ifdef MULDIV_FAST_MUL_EN
            state_reg    <= bus.op[1] ? RUN : FAST;
`else
            state_reg    <= RUN;
`endif
          end else begin
            // mthi/mtlo only land while idle; a same-cycle start wins.
            if (bus.wr_hi) hi_reg <= bus.wdata;
            if (bus.wr_lo) lo_reg <= bus.wdata;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_reg <= IDLE;
          end else begin
            work_reg <= is_div_reg ? div_next : mul_next;
            if (cnt_reg == CNT_W'(WIDTH-1)) state_reg <= FIN;
            else                            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
`ifdef MULDIV_FAST_MUL_EN
        FAST: begin
          if (bus.flush) begin
            state_reg <= IDLE;
          end else begin
            work_reg  <= {{WIDTH{1'b0}}, work_reg[WIDTH-1:0]} * {{WIDTH{1'b0}}, mcand_reg};
            state_reg <= FIN;
          end
        end
`endif
        FIN: begin
          if (bus.flush) begin
            state_reg <= IDLE;
          end else begin
            hi_reg    <= res_hi;
            lo_reg    <= res_lo;
            done_reg  <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            state_reg <= is_div_reg ? DONE : IDLE;
`else
            state_reg <= DONE;
`endif
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.done  = done_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.rd_hilo | bus.wr_hi | bus.wr_lo);

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Iterative multiply/divide sequencer beside the EX stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu from EX and runs a 32-step shift-add or restoring-divide engine.
- Holds the HI/LO architectural registers and serves mfhi/mflo/mthi/mtlo.
- Drives a stall request that the hazard logic ORs into Stall while the unit is busy.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  pipeline clock (the divided clock domain).
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  EX holds a mul/div op this cycle.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  rs operand (after forwarding).
- b  in  WIDTH  rt operand (after forwarding).
- flush  in  1  cancels the in-flight op (e.g. exception/redirect).
- rd_hilo  in  1  EX holds mfhi/mflo this cycle.
- wr_hi  in  1  mthi.
- wr_lo  in  1  mtlo.
- wdata  in  WIDTH  mthi/mtlo data.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  engine is not IDLE.
- done  out  1  one-cycle pulse when HI/LO take a result.
- stall  out  1  stall request to the pipeline.

Behaviour:
- Reset (async, any state): state=IDLE; hi, lo, counter and work registers = 0; busy=done=stall=0.
- States:
  - IDLE: start=1 and flush=0 -> latch op, |a|, |b|, sign flags; counter=0; go RUN.
  - RUN: one iteration per edge. After the edge with counter==WIDTH-1 -> DONE.
  - DONE: write hi/lo, done=1 for this cycle only, then IDLE.
- Latency: start sampled at edge N; hi/lo updated and done=1 after edge N+33; busy low after edge N+34.
- Multiply:
  - 64-bit product from WIDTH add/shift steps.
  - mult: operands made unsigned; product negated in DONE if a[31]^b[31].
  - hi = product[63:32], lo = product[31:0].
- Divide:
  - Restoring; lo = quotient, hi = remainder.
  - div: quotient negative if signs differ; remainder takes the dividend's sign.
  - b==0 (div or divu): no trap; hi = a, lo = all ones. Iterations still run; latency unchanged.
- stall = busy & (start | rd_hilo | wr_hi | wr_lo).
  - The instruction in EX is held until the unit is idle.
  - start while busy is never accepted.
- mthi/mtlo:
  - Apply at the edge when not busy.
  - wr_hi and wr_lo in the same cycle both apply.
  - A simultaneous start in IDLE takes priority; the write is dropped (cannot occur legally in a single-issue pipe).
- hi/lo outputs are registers. mfhi in the cycle after done reads the new values.
- flush:
  - In RUN or DONE: go IDLE next edge; hi/lo unchanged; done stays 0.
  - In IDLE with start: start is ignored.
- Counter stops at WIDTH-1 and never wraps. A counter value above WIDTH-1 is unreachable.

Optional Feature:
- MULDIV_FAST_MUL_EN
- Defined:
  - mult/multu skip RUN. IDLE -> DONE using a single-cycle signed/unsigned WIDTH x WIDTH product.
  - hi/lo update and done=1 after edge N+2; busy for 2 cycles.
  - Division is unchanged.
- Undefined: all ops take the iterative 34-cycle path described above.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> done after 33 edges; hi=0xFFFFFFFE, lo=0x00000001; stall high while rd_hilo is held during busy.
- mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=0x12345678 b=0 -> hi=0x12345678, lo=0xFFFFFFFF; latency unchanged, no hang.
- Start divu 100/7, assert flush at RUN cycle 10 -> IDLE next edge; hi/lo keep prior values; done never pulses.
- Async reset at RUN cycle 20 -> hi=lo=0, busy=0 immediately (before the next edge). A new start afterwards completes normally.
- mthi 0xA5A5A5A5 while idle -> hi updates next edge. mtlo while busy -> stall=1 and lo unchanged until the op finishes. With MULDIV_FAST_MUL_EN: mult 6*7 -> lo=42 after 2 edges.
